// File: rtl/riscv_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// riscv_uart_tx_pkg
//   Shared constants and types for the memory-mapped UART transmitter:
//   register offsets inside the 8-byte window, STATUS bit positions, the
//   transmit FSM state encoding and a helper that packs the STATUS word.
// ---------------------------------------------------------------------------
package riscv_uart_tx_pkg;

    // Register offsets inside the window (bits [1:0] are ignored on decode)
    localparam logic [2:0] UART_TXDATA_OFF = 3'h0;
    localparam logic [2:0] UART_STATUS_OFF = 3'h4;

    // STATUS bit positions
    localparam int UART_ST_FULL  = 0;
    localparam int UART_ST_EMPTY = 1;
    localparam int UART_ST_BUSY  = 2;
    localparam int UART_ST_OVF   = 3;

    // Transmit FSM states
    typedef enum logic [1:0] {
        UART_IDLE  = 2'b00,
        UART_START = 2'b01,
        UART_DATA  = 2'b10,
        UART_STOP  = 2'b11
    } uart_state_e;

    // Packs the individual status flags into the 32-bit word seen by loads.
    function automatic logic [31:0] uart_status_word(
        input logic full,
        input logic empty,
        input logic busy,
        input logic ovf
    );
        logic [31:0] word;
        word                = '0;
        word[UART_ST_FULL]  = full;
        word[UART_ST_EMPTY] = empty;
        word[UART_ST_BUSY]  = busy;
        word[UART_ST_OVF]   = ovf;
        return word;
    endfunction

endpackage

// File: rtl/riscv_uart_tx_if.sv
// ---------------------------------------------------------------------------
// riscv_uart_tx_if
//   Core data-memory port as seen by the UART transmitter.
//   data_ce_i   : data-port enable
//   data_we_i   : store strobe
//   data_addr_i : byte address
//   data_i      : store data (bits [7:0] feed TXDATA)
//   sel_o       : address falls inside the UART window (read-mux select)
//   data_o      : combinational read data
//   master = core side, slave = UART side.
// ---------------------------------------------------------------------------
interface riscv_uart_tx_if;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_i;
    logic        sel_o;
    logic [31:0] data_o;

    modport master (
        output data_ce_i,
        output data_we_i,
        output data_addr_i,
        output data_i,
        input  sel_o,
        input  data_o
    );

    modport slave (
        input  data_ce_i,
        input  data_we_i,
        input  data_addr_i,
        input  data_i,
        output sel_o,
        output data_o
    );
endinterface

// File: rtl/riscv_fifo.sv
// ---------------------------------------------------------------------------
// riscv_fifo
//   Synchronous FIFO with combinational head output.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (pointers and count)
//   push  : write din at the tail; accepted if not full or if a pop
//           happens in the same cycle
//   pop   : remove the head; ignored while empty
//   din   : write data
//   dout  : current head entry (combinational)
//   full  : count == DEPTH
//   empty : count == 0
//   count : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module riscv_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO still succeeds when the head leaves this cycle
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/riscv_uart_tx.sv
// ---------------------------------------------------------------------------
// riscv_uart_tx
//   Memory-mapped 8N1 UART transmitter on the core data-memory port.
//   Window of 8 bytes at BASE_ADDR:
//     +0 TXDATA : store pushes data_i[7:0] into the TX FIFO, load returns 0
//     +4 STATUS : load returns {28'b0, ovf, busy, empty, full},
//                 store of any value clears the sticky overflow flag
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : core data port (slave modport); sel_o/data_o are combinational
//   tx_o  : registered serial output, idle high
//   irq_o : registered, high when the FIFO is empty and the FSM is idle
// ---------------------------------------------------------------------------
module riscv_uart_tx
    import riscv_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_uart_tx_if.slave        bus,
    output logic                  tx_o,
    output logic                  irq_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // ---------------- bus decode ----------------
    logic        is_txdata;
    logic        is_status;
    logic        push;
    logic        status_wr;
    logic        store;
    logic        unused_bits;

    assign bus.sel_o = (bus.data_addr_i[31:3] == BASE_ADDR[31:3]);
    assign is_txdata = (bus.data_addr_i[2] == UART_TXDATA_OFF[2]);
    assign is_status = (bus.data_addr_i[2] == UART_STATUS_OFF[2]);
    assign store     = bus.data_ce_i & bus.data_we_i & bus.sel_o;
    assign push      = store & is_txdata;
    assign status_wr = store & is_status;

    // Byte lanes inside a word and the upper store data are don't-care
    assign unused_bits = ^{bus.data_addr_i[1:0], bus.data_i[31:8]};

    // ---------------- TX FIFO ----------------
    logic             pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    riscv_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.data_i[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- state ----------------
    uart_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             irq_q, irq_d;
    logic             ovf_q, ovf_d;
    logic             div_last;

    assign div_last = (div_cnt_q == DIV_LAST);

    // Next-state logic of the serialiser. tx_d is the line level for the
    // state being entered, so tx_o changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_dout;
                    div_cnt_d = '0;
                    tx_d      = 1'b0;
                    state_d   = UART_START;
                end
            end
            UART_START: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = UART_DATA;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            UART_DATA: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = UART_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            UART_STOP: begin
                tx_d = 1'b1;
                if (div_last) begin
                    div_cnt_d = '0;
                    state_d   = UART_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = UART_IDLE;
            end
        endcase
    end

    // Sticky overflow: a push that the FIFO cannot take sets it, a STATUS
    // store clears it, and the clear has priority when both coincide.
    always_comb begin
        ovf_d = ovf_q;
        if (status_wr) begin
            ovf_d = 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Transmit-done interrupt is sampled from the current cycle's state
    always_comb begin
        irq_d = (fifo_count == '0) && (state_q == UART_IDLE);
    end

    // All FSM and output registers; reset leaves the line high at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UART_IDLE;
            div_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
        end
    end

    // ---------------- outputs ----------------
    assign tx_o  = tx_q;
    assign irq_o = irq_q;

    assign bus.data_o = (bus.sel_o && is_status)
                      ? uart_status_word(fifo_full, fifo_empty,
                                         state_q != UART_IDLE, ovf_q)
                      : 32'h0;

endmodule

// File: tb/tb_riscv_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_riscv_uart_tx
//   Directed self-checking bench for riscv_uart_tx with CLK_DIV=4,
//   FIFO_DEPTH=4, BASE_ADDR=32'h1000_0000. Inputs change 1 ns after the
//   rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_riscv_uart_tx;

    localparam logic [31:0] BASE_ADDR   = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;
    localparam int          CLK_DIV     = 4;
    localparam int          FRAME_LEN   = 10 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic irq;

    int checks   = 0;
    int failures = 0;

    riscv_uart_tx_if bus_if ();

    riscv_uart_tx #(
        .BASE_ADDR  (BASE_ADDR),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if),
        .tx_o  (tx),
        .irq_o (irq)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Drives the core data port
    task automatic applyStimulus(input logic ce, input logic we,
                                 input logic [31:0] addr, input logic [31:0] data);
        bus_if.data_ce_i   = ce;
        bus_if.data_we_i   = we;
        bus_if.data_addr_i = addr;
        bus_if.data_i      = data;
    endtask

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Single-cycle store; returns 1 ns after the edge that takes it
    task automatic storeWord(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, data);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Combinational STATUS load, no clock edge involved
    task automatic checkStatus(input string tag, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, STATUS_ADDR, 32'h0);
        #1;
        checkOutput(tag, bus_if.data_o, expected);
        checkOutput($sformatf("%s_sel", tag), {31'b0, bus_if.sel_o}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Checks line levels of frame cycles first..FRAME_LEN-1, one per edge;
    // cycle 0 is the first start-bit cycle.
    task automatic expectFrame(input logic [7:0] b, input int first, input string tag);
        logic expLevel;
        for (int i = first; i < FRAME_LEN; i++) begin
            @(posedge clk);
            #1;
            if (i < CLK_DIV) begin
                expLevel = 1'b0;
            end else if (i < 9 * CLK_DIV) begin
                expLevel = b[(i - CLK_DIV) / CLK_DIV];
            end else begin
                expLevel = 1'b1;
            end
            checkOutput($sformatf("%s_c%0d", tag, i), {31'b0, tx}, {31'b0, expLevel});
        end
    endtask

    // Line must stay high for n edges
    task automatic expectIdle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s_%0d", tag, i), {31'b0, tx}, 32'h1);
        end
    endtask

    // Guards against a run that never finishes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx_held", {31'b0, tx}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_irq", {31'b0, irq}, 32'h1);
        checkStatus("rst_status", 32'h2);
        expectIdle(4, "rst_idle");

        // ---- single byte 0xA5 ----
        storeWord(BASE_ADDR, 32'h0000_00A5);
        checkOutput("a5_pre", {31'b0, tx}, 32'h1);
        checkStatus("a5_queued", 32'h0);
        @(posedge clk);
        #1;
        checkOutput("a5_start", {31'b0, tx}, 32'h0);
        checkOutput("a5_irq_busy", {31'b0, irq}, 32'h0);
        checkStatus("a5_busy", 32'h6);
        expectFrame(8'hA5, 1, "a5");
        @(posedge clk);
        #1;
        checkOutput("a5_after_tx", {31'b0, tx}, 32'h1);
        checkOutput("a5_irq_late", {31'b0, irq}, 32'h0);
        checkStatus("a5_done_status", 32'h2);
        @(posedge clk);
        #1;
        checkOutput("a5_irq_done", {31'b0, irq}, 32'h1);

        // ---- six back-to-back stores, FIFO overflow ----
        for (int k = 1; k <= 6; k++) begin
            storeWord(BASE_ADDR, 32'(k));
        end
        // full + overflow, and busy since byte 0x01 is already on the line
        checkStatus("ovf_status", 32'hD);
        checkOutput("ovf_irq", {31'b0, irq}, 32'h0);
        storeWord(STATUS_ADDR, 32'hFFFF_FFFF);
        checkStatus("ovf_cleared", 32'h5);
        // the clear store landed during cycle 5 of the first frame
        expectFrame(8'h01, 6, "b01");
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("gap_%0d", k), {31'b0, tx}, 32'h1);
            expectFrame(8'(k), 0, $sformatf("b%02h", k));
        end
        expectIdle(2, "post_burst");
        checkOutput("burst_irq", {31'b0, irq}, 32'h1);
        checkStatus("burst_status", 32'h2);
        expectIdle(12, "no_sixth");

        // ---- out-of-window accesses ----
        applyStimulus(1'b1, 1'b1, 32'h1000_0008, 32'h0000_0077);
        #1;
        checkOutput("oow_hi_sel", {31'b0, bus_if.sel_o}, 32'h0);
        checkOutput("oow_hi_data", bus_if.data_o, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0);
        #1;
        checkOutput("oow_lo_sel", {31'b0, bus_if.sel_o}, 32'h0);
        checkOutput("oow_lo_data", bus_if.data_o, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0FFF_FFFC, 32'h0000_0033);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, BASE_ADDR, 32'h0);
        #1;
        checkOutput("txdata_load_sel", {31'b0, bus_if.sel_o}, 32'h1);
        checkOutput("txdata_load_data", bus_if.data_o, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h1000_0007, 32'h0);
        #1;
        checkOutput("status_byte_addr", bus_if.data_o, 32'h2);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkStatus("oow_status", 32'h2);
        expectIdle(6, "oow_idle");

        // ---- unaligned TXDATA store, then reset mid-frame ----
        storeWord(32'h1000_0001, 32'h0000_0055);
        checkStatus("addr1_queued", 32'h0);
        storeWord(BASE_ADDR, 32'h0000_00AA);
        storeWord(BASE_ADDR, 32'h0000_000F);
        checkStatus("two_queued", 32'h4);
        // frame cycle 9 carries bit 1 of 0x55, which is low
        repeat (8) @(posedge clk);
        #1;
        checkOutput("pre_reset_low", {31'b0, tx}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_tx", {31'b0, tx}, 32'h1);
        checkOutput("async_rst_irq", {31'b0, irq}, 32'h1);
        checkStatus("async_rst_status", 32'h2);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expectIdle(50, "post_rst");
        checkStatus("post_rst_status", 32'h2);
        checkOutput("post_rst_irq", {31'b0, irq}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
